// File: rtl/fifo_rr_scheduler.sv
// Round-robin mover from four input FIFOs to four output FIFOs, one word per
// ARB -> READ -> WRITE pass; the two MSBs of each word select the output FIFO.
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic [3:0]              in_empty,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [3:0]              out_pause,
  input  logic [3:0]              out_full,
  input  logic                    enable,
  output logic [3:0]              pop,
  output logic [3:0]              push,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    xfer_count,
  output logic [1:0]              fsm_state
);

  // Flow control: pop/push are one-cycle strobes with no ready return; a pop
  // is only issued when the input is non-empty, and a push only when the
  // addressed output is not full (pause gates new grants, not pushes).

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [3:0]              pop_nx, push_nx;
  logic [DATA_WIDTH-1:0]   data_nx;
  logic [1:0]              grant_nx;
  logic [CNT_WIDTH-1:0]    cnt_nx;
  logic [1:0]              rr_idx, cand, dest;
  logic                    rr_found;

  assign fsm_state = state;
  assign dest      = data_out[DATA_WIDTH-1:DATA_WIDTH-2];

  // Search starts one past the last grant; the last grant itself is checked last.
  always_comb begin
    rr_idx   = grant;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = grant + 2'(k);
      if (!rr_found && !in_empty[cand]) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pop_nx   = '0;
    push_nx  = '0;
    data_nx  = data_out;
    grant_nx = grant;
    cnt_nx   = xfer_count;
    case (state)
      ARB: begin
        if (enable && (out_pause == 4'b0000) && rr_found) begin
          grant_nx = rr_idx;
          pop_nx   = 4'b0001 << rr_idx;
          state_nx = READ;
        end
      end
      READ: begin
        data_nx  = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        state_nx = WRITE;
      end
      WRITE: begin
        if (!out_full[dest]) begin
          push_nx  = 4'b0001 << dest;
          cnt_nx   = xfer_count + CNT_WIDTH'(1);
          state_nx = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ARB;
      pop        <= '0;
      push       <= '0;
      data_out   <= '0;
      grant      <= 2'd3;
      busy       <= 1'b0;
      xfer_count <= '0;
    end else begin
      state      <= state_nx;
      pop        <= pop_nx;
      push       <= push_nx;
      data_out   <= data_nx;
      grant      <= grant_nx;
      busy       <= (state_nx != ARB);
      xfer_count <= cnt_nx;
    end
  end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
Round-robin scheduler that moves 6-bit words from four input FIFOs into four output FIFOs. It picks one non-empty input FIFO, pops one word, and routes the word to the output FIFO addressed by its two MSBs. It honours the output FIFOs' Pausa/Fifo_Full flow control and sits between the input and output banks of fifo instances.

Parameters:
DATA_WIDTH, 6, word width. The destination field is always bits [DATA_WIDTH-1:DATA_WIDTH-2].
CNT_WIDTH, 8, width of the transferred-word counter.

Ports:
clk  in  1  system clock, rising edge
reset_L  in  1  asynchronous active-low reset
in_empty  in  4  Fifo_Empty of input FIFOs 3..0
in_data  in  4*DATA_WIDTH  Fifo_Data_out of input FIFOs; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
out_pause  in  4  Pausa of output FIFOs 3..0
out_full  in  4  Fifo_Full of output FIFOs 3..0
enable  in  1  1 = scheduler runs; 0 = finish the word in flight, then hold in ARB
pop  out  4  one-hot pop to input FIFOs, registered
push  out  4  one-hot push to output FIFOs, registered
data_out  out  DATA_WIDTH  word driven to all output FIFO Fifo_Data_in, registered
grant  out  2  index of the input currently or last served
busy  out  1  1 when the state is not ARB
xfer_count  out  CNT_WIDTH  words pushed since reset; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, reset_L=0):
  - state=ARB.
  - pop=0, push=0, data_out=0, grant=3 (so input 0 has first priority).
  - busy=0, xfer_count=0.
  - Any word in flight is lost.
- FSM states: ARB, READ, WRITE. All outputs are registered.
- ARB:
  - Inputs are eligible when in_empty[i]=0.
  - Global gate: enable=1 and out_pause==0. Any output at Pausa blocks new grants because the destination is unknown before the read.
  - If any input is eligible: g = first eligible index searching (grant+1), (grant+2), (grant+3), grant, mod 4. Then grant<=g, pop<=onehot(g), state<=READ.
  - Otherwise stay in ARB with pop=0.
- READ:
  - pop<=0. The FIFO memory presents the word in this cycle (one-cycle registered read).
  - data_out<=in_data[grant], state<=WRITE.
- WRITE:
  - d = data_out[DATA_WIDTH-1:DATA_WIDTH-2].
  - If out_full[d]=0: push<=onehot(d), xfer_count<=xfer_count+1, state<=ARB.
  - If out_full[d]=1: push=0, stay in WRITE (stall) with data_out held. out_pause does not stall WRITE; only full does.
- push is high for exactly one cycle, the first ARB cycle after WRITE. pop may assert at the same edge as that push is deasserted.
- Throughput: max 1 word per 3 cycles. Latency from pop high to push high is 2 cycles with no stall.
- pop and push are never asserted more than one cycle per word. pop is never issued to an input with in_empty=1 at the decision edge.
- enable=0 mid-transfer: the READ/WRITE sequence completes, then the block waits in ARB.
- xfer_count wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
1. Reset; in_empty=1111 -> pop=0, push=0, busy=0, grant=3, xfer_count=0 held for 10 cycles.
2. Only input 2 non-empty, holding 0x25 (dest=2) -> pop=0100 for 1 cycle; 2 cycles later push=0100 with data_out=0x25; xfer_count=1.
3. All inputs non-empty continuously, all dests 0 -> grants rotate 0,1,2,3,0 with one pop every 3 cycles and no starvation.
4. Word 0x3F (dest=3) with out_full[3]=1 for 5 cycles -> stays in WRITE, push=0, data_out=0x3F stable; push=1000 on the first ARB cycle after full drops.
5. out_pause=0010 while inputs are non-empty -> no pop issued; the in-flight word still completes; grants resume one cycle after pause clears.
6. reset_L low during READ -> outputs clear immediately (asynchronously); after release, arbitration restarts from input 0.
